// File: rtl/hz_stage_tracker.sv
// Hazard-record shift chain (ID -> EX -> MEM -> WB) feeding the hazard/forwarding controller.
// Optional mult/div busy tracker enabled by defining HZ_MD_BUSY_EN.
module hz_stage_tracker #(
   parameter int TW          = 4,
   parameter int MD_MULT_CYC = 5,
   parameter int MD_DIV_CYC  = 10
) (
   input  logic          clk,
   input  logic          reset,
`ifdef HZ_MD_BUSY_EN
   input  logic          md_start,
   input  logic          md_is_div,
   input  logic          md_use,
   output logic          md_busy,
   output logic          md_stall,
`endif
   input  logic [4:0]    ID_Rs,
   input  logic [4:0]    ID_Rt,
   input  logic [4:0]    ID_WA,
   input  logic          ID_RegWrite,
   input  logic          ID_MemtoReg,
   input  logic [TW-1:0] ID_Tnew,
   input  logic          ID_clr,
   input  logic          pipe_stall,
   output logic [4:0]    EX_Rs,
   output logic [4:0]    EX_Rt,
   output logic [4:0]    EX_WA,
   output logic          EX_RegWrite,
   output logic          EX_MemtoReg,
   output logic [TW-1:0] EX_Tnew,
   output logic [4:0]    MEM_WA,
   output logic          MEM_RegWrite,
   output logic          MEM_MemtoReg,
   output logic [TW-1:0] MEM_Tnew,
   output logic [4:0]    WB_WA,
   output logic          WB_RegWrite,
   output logic [TW-1:0] WB_Tnew
);

   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
      return (x == '0) ? '0 : x - 1'b1;
   endfunction

   logic [4:0]    ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_wa_q, ex_wa_d;
   logic          ex_rw_q, ex_rw_d, ex_m2r_q, ex_m2r_d;
   logic [TW-1:0] ex_tn_q, ex_tn_d;
   logic [4:0]    mem_wa_q, mem_wa_d;
   logic          mem_rw_q, mem_rw_d, mem_m2r_q, mem_m2r_d;
   logic [TW-1:0] mem_tn_q, mem_tn_d;
   logic [4:0]    wb_wa_q, wb_wa_d;
   logic          wb_rw_q, wb_rw_d;
   logic [TW-1:0] wb_tn_q, wb_tn_d;

   always_comb begin
      ex_rs_d   = ex_rs_q;
      ex_rt_d   = ex_rt_q;
      ex_wa_d   = ex_wa_q;
      ex_rw_d   = ex_rw_q;
      ex_m2r_d  = ex_m2r_q;
      ex_tn_d   = ex_tn_q;
      mem_wa_d  = mem_wa_q;
      mem_rw_d  = mem_rw_q;
      mem_m2r_d = mem_m2r_q;
      mem_tn_d  = mem_tn_q;
      wb_wa_d   = wb_wa_q;
      wb_rw_d   = wb_rw_q;
      wb_tn_d   = wb_tn_q;
      if (!pipe_stall) begin
         // A freeze also swallows ID_clr; hazard control re-asserts it when unfrozen.
         if (ID_clr) begin
            ex_rs_d  = '0;
            ex_rt_d  = '0;
            ex_wa_d  = '0;
            ex_rw_d  = 1'b0;
            ex_m2r_d = 1'b0;
            ex_tn_d  = '0;
         end else begin
            ex_rs_d  = ID_Rs;
            ex_rt_d  = ID_Rt;
            ex_wa_d  = ID_WA;
            ex_rw_d  = ID_RegWrite & (ID_WA != 5'd0);
            ex_m2r_d = ID_MemtoReg;
            ex_tn_d  = ID_Tnew;
         end
         mem_wa_d  = ex_wa_q;
         mem_rw_d  = ex_rw_q;
         mem_m2r_d = ex_m2r_q;
         mem_tn_d  = sat_dec(ex_tn_q);
         wb_wa_d   = mem_wa_q;
         wb_rw_d   = mem_rw_q;
         wb_tn_d   = sat_dec(mem_tn_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_rs_q   <= '0;
         ex_rt_q   <= '0;
         ex_wa_q   <= '0;
         ex_rw_q   <= 1'b0;
         ex_m2r_q  <= 1'b0;
         ex_tn_q   <= '0;
         mem_wa_q  <= '0;
         mem_rw_q  <= 1'b0;
         mem_m2r_q <= 1'b0;
         mem_tn_q  <= '0;
         wb_wa_q   <= '0;
         wb_rw_q   <= 1'b0;
         wb_tn_q   <= '0;
      end else begin
         ex_rs_q   <= ex_rs_d;
         ex_rt_q   <= ex_rt_d;
         ex_wa_q   <= ex_wa_d;
         ex_rw_q   <= ex_rw_d;
         ex_m2r_q  <= ex_m2r_d;
         ex_tn_q   <= ex_tn_d;
         mem_wa_q  <= mem_wa_d;
         mem_rw_q  <= mem_rw_d;
         mem_m2r_q <= mem_m2r_d;
         mem_tn_q  <= mem_tn_d;
         wb_wa_q   <= wb_wa_d;
         wb_rw_q   <= wb_rw_d;
         wb_tn_q   <= wb_tn_d;
      end
   end

   assign EX_Rs        = ex_rs_q;
   assign EX_Rt        = ex_rt_q;
   assign EX_WA        = ex_wa_q;
   assign EX_RegWrite  = ex_rw_q;
   assign EX_MemtoReg  = ex_m2r_q;
   assign EX_Tnew      = ex_tn_q;
   assign MEM_WA       = mem_wa_q;
   assign MEM_RegWrite = mem_rw_q;
   assign MEM_MemtoReg = mem_m2r_q;
   assign MEM_Tnew     = mem_tn_q;
   assign WB_WA        = wb_wa_q;
   assign WB_RegWrite  = wb_rw_q;
   assign WB_Tnew      = wb_tn_q;

`ifdef HZ_MD_BUSY_EN
   localparam int MD_MAX = (MD_DIV_CYC > MD_MULT_CYC) ? MD_DIV_CYC : MD_MULT_CYC;
   localparam int MDW    = $clog2(MD_MAX + 1);

   logic [MDW-1:0] md_cnt_q, md_cnt_d;

   // A start seen while the counter is running is ignored, so the window never stretches.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_cnt_q == '0) begin
         if (md_start)
            md_cnt_d = md_is_div ? MDW'(MD_DIV_CYC) : MDW'(MD_MULT_CYC);
      end else if (!pipe_stall) begin
         md_cnt_d = md_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) md_cnt_q <= '0;
      else       md_cnt_q <= md_cnt_d;
   end

   assign md_busy  = (md_cnt_q != '0) | md_start;
   assign md_stall = md_busy & md_use;
`endif

endmodule

// File: tb/tb_hz_stage_tracker.sv
// Directed vector table plus randomized run against a slot-based reference model.
module tb_hz_stage_tracker;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    ID_Rs, ID_Rt, ID_WA;
   logic          ID_RegWrite, ID_MemtoReg, ID_clr, pipe_stall;
   logic [TW-1:0] ID_Tnew;
   logic [4:0]    EX_Rs, EX_Rt, EX_WA, MEM_WA, WB_WA;
   logic          EX_RegWrite, EX_MemtoReg, MEM_RegWrite, MEM_MemtoReg, WB_RegWrite;
   logic [TW-1:0] EX_Tnew, MEM_Tnew, WB_Tnew;

   always #5 clk = ~clk;

   hz_stage_tracker #(.TW(TW)) dut (
      .clk(clk), .reset(reset),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_WA(ID_WA),
      .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg), .ID_Tnew(ID_Tnew),
      .ID_clr(ID_clr), .pipe_stall(pipe_stall),
      .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WA(EX_WA),
      .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_Tnew(EX_Tnew),
      .MEM_WA(MEM_WA), .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
      .MEM_Tnew(MEM_Tnew),
      .WB_WA(WB_WA), .WB_RegWrite(WB_RegWrite), .WB_Tnew(WB_Tnew)
   );

   logic [41:0] act;
   assign act = {EX_Rs, EX_Rt, EX_WA, EX_RegWrite, EX_MemtoReg, EX_Tnew,
                 MEM_WA, MEM_RegWrite, MEM_MemtoReg, MEM_Tnew,
                 WB_WA, WB_RegWrite, WB_Tnew};

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit          rst, clr, stall;
      int          rs, rt, wa, rw, m2r, tn;
      logic [41:0] exp;
   } vec_t;

   typedef struct {
      int rs, rt, wa, rw, m2r, tn;
   } rec_t;

   function automatic logic [41:0] mkexp(int ers, int ert, int ewa, int erw, int em, int et,
                                         int mwa, int mrw, int mm, int mt,
                                         int wwa, int wrw, int wt);
      return {5'(ers), 5'(ert), 5'(ewa), 1'(erw), 1'(em), 4'(et),
              5'(mwa), 1'(mrw), 1'(mm), 4'(mt), 5'(wwa), 1'(wrw), 4'(wt)};
   endfunction

   function automatic vec_t mkv(bit rst, bit clr, bit stall, int rs, int rt, int wa,
                                int rw, int m2r, int tn, logic [41:0] exp);
      vec_t v;
      v.rst = rst; v.clr = clr; v.stall = stall;
      v.rs = rs; v.rt = rt; v.wa = wa; v.rw = rw; v.m2r = m2r; v.tn = tn;
      v.exp = exp;
      return v;
   endfunction

   function automatic int sat(int x);
      return (x < 0) ? 0 : x;
   endfunction

   task automatic drive(bit rst, bit clr, bit stall, int rs, int rt, int wa,
                        int rw, int m2r, int tn);
      reset = rst; ID_clr = clr; pipe_stall = stall;
      ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_WA = 5'(wa);
      ID_RegWrite = 1'(rw); ID_MemtoReg = 1'(m2r); ID_Tnew = 4'(tn);
   endtask

   task automatic chk(string name, logic [41:0] a, logic [41:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: outputs %h, expected %h", name, a, e);
      end
   endtask

   vec_t tv[16];
   rec_t ex_s, mem_s, wb_s, id_r;
   rec_t zero_r;

   initial begin
      zero_r = '{0, 0, 0, 0, 0, 0};
      tv[0]  = mkv(1,0,0, 0,0,0,0,0,0, mkexp(0,0,0,0,0,0, 0,0,0,0, 0,0,0));
      tv[1]  = mkv(1,0,0, 0,0,0,0,0,0, mkexp(0,0,0,0,0,0, 0,0,0,0, 0,0,0));
      tv[2]  = mkv(0,0,0, 1,2,8,1,1,2, mkexp(1,2,8,1,1,2, 0,0,0,0, 0,0,0));
      tv[3]  = mkv(0,0,0, 0,0,0,0,0,0, mkexp(0,0,0,0,0,0, 8,1,1,1, 0,0,0));
      tv[4]  = mkv(0,0,0, 0,0,0,0,0,0, mkexp(0,0,0,0,0,0, 0,0,0,0, 8,1,0));
      tv[5]  = mkv(0,0,0, 4,0,0,1,0,3, mkexp(4,0,0,0,0,3, 0,0,0,0, 0,0,0));
      tv[6]  = mkv(0,0,0, 0,0,3,1,0,1, mkexp(0,0,3,1,0,1, 0,0,0,2, 0,0,0));
      tv[7]  = mkv(0,1,0, 7,0,5,1,0,2, mkexp(0,0,0,0,0,0, 3,1,0,0, 0,0,1));
      tv[8]  = mkv(0,0,0, 0,0,2,1,0,1, mkexp(0,0,2,1,0,1, 0,0,0,0, 3,1,0));
      tv[9]  = mkv(0,0,0, 0,0,4,1,0,2, mkexp(0,0,4,1,0,2, 2,1,0,0, 0,0,0));
      tv[10] = mkv(0,0,0, 0,0,9,1,1,3, mkexp(0,0,9,1,1,3, 4,1,0,1, 2,1,0));
      tv[11] = mkv(0,1,1, 0,0,7,1,0,1, mkexp(0,0,9,1,1,3, 4,1,0,1, 2,1,0));
      tv[12] = mkv(0,1,1, 0,0,7,1,0,1, mkexp(0,0,9,1,1,3, 4,1,0,1, 2,1,0));
      tv[13] = mkv(0,0,0, 0,0,0,0,0,0, mkexp(0,0,0,0,0,0, 9,1,1,2, 4,1,0));
      tv[14] = mkv(1,1,1, 0,0,6,1,0,5, mkexp(0,0,0,0,0,0, 0,0,0,0, 0,0,0));
      tv[15] = mkv(0,0,0, 0,0,0,0,0,0, mkexp(0,0,0,0,0,0, 0,0,0,0, 0,0,0));

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         drive(tv[i].rst, tv[i].clr, tv[i].stall, tv[i].rs, tv[i].rt, tv[i].wa,
               tv[i].rw, tv[i].m2r, tv[i].tn);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d", i), act, tv[i].exp);
      end

      // Model keeps each stage's original ID record; Tnew ages by stage index.
      ex_s = zero_r; mem_s = zero_r; wb_s = zero_r;
      for (int c = 0; c < 500; c++) begin
         bit rst, clr, stall;
         rst   = ($urandom_range(0, 39) == 0);
         clr   = ($urandom_range(0, 4) == 0);
         stall = ($urandom_range(0, 4) == 0);
         id_r.rs  = $urandom_range(0, 31);
         id_r.rt  = $urandom_range(0, 31);
         id_r.wa  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
         id_r.rw  = $urandom_range(0, 1);
         id_r.m2r = $urandom_range(0, 1);
         id_r.tn  = $urandom_range(0, 15);
         drive(rst, clr, stall, id_r.rs, id_r.rt, id_r.wa, id_r.rw, id_r.m2r, id_r.tn);
         @(posedge clk);
         if (rst) begin
            ex_s = zero_r; mem_s = zero_r; wb_s = zero_r;
         end else if (!stall) begin
            wb_s  = mem_s;
            mem_s = ex_s;
            if (clr) ex_s = zero_r;
            else begin
               ex_s = id_r;
               if (id_r.wa == 0) ex_s.rw = 0;
            end
         end
         @(negedge clk);
         chk($sformatf("rand%0d", c), act,
             mkexp(ex_s.rs, ex_s.rt, ex_s.wa, ex_s.rw, ex_s.m2r, ex_s.tn,
                   mem_s.wa, mem_s.rw, mem_s.m2r, sat(mem_s.tn - 1),
                   wb_s.wa, wb_s.rw, sat(wb_s.tn - 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
